// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned CNT_W = 6;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StMultRun,
        StDivRun,
        StWrite,
        StDivz
    } state_e;

endpackage

// File: rtl/muldiv_cnt.sv
// Loadable down-counter timing the multiply/divide unit latency.
module muldiv_cnt
    import muldiv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the external multiply/divide units and the HI/LO write-back.
// All outputs come straight from flops, computed from the next state.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_mult_i,
    input  logic        start_div_i,
    input  logic        flush_i,
    input  logic [31:0] divisor_i,
    output logic        init_mult_o,
    output logic        init_div_o,
    output logic        op_hi_o,
    output logic        op_lo_o,
    output logic        hi_write_o,
    output logic        lo_write_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_o
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             init_mult_q, init_mult_d, init_div_q, init_div_d;
    logic             write_q, write_d, busy_q, busy_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;

    muldiv_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_mult_i) begin
                    state_d  = StMultRun;
                    op_d     = OP_MULT;
                    cnt_load = 1'b1;
                    cnt_val  = MultLoad;
                end else if (start_div_i) begin
                    if (divisor_i != '0) begin
                        state_d  = StDivRun;
                        op_d     = OP_DIV;
                        cnt_load = 1'b1;
                        cnt_val  = DivLoad;
                    end else begin
                        state_d = StDivz;
                    end
                end
            end
            StMultRun, StDivRun: begin
                if (cnt_zero) begin
                    state_d = StWrite;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWrite, StDivz: state_d = StIdle;
            default:         state_d = StIdle;
        endcase

        // Abort beats both a new start and counter expiry; the mux select is left untouched.
        if (flush_i) begin
            state_d  = StIdle;
            op_d     = op_q;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end

        init_mult_d = (state_q == StIdle) && (state_d == StMultRun);
        init_div_d  = (state_q == StIdle) && (state_d == StDivRun);
        write_d     = (state_d == StWrite);
        div_zero_d  = (state_d == StDivz);
        done_d      = write_d || div_zero_d;
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_q        <= OP_DIV;
            init_mult_q <= 1'b0;
            init_div_q  <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            init_mult_q <= init_mult_d;
            init_div_q  <= init_div_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign init_mult_o = init_mult_q;
    assign init_div_o  = init_div_q;
    assign op_hi_o     = op_q;
    assign op_lo_o     = op_q;
    assign hi_write_o  = write_q;
    assign lo_write_o  = write_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: per-cycle output vectors against hand-derived values.
module tb_muldiv_ctrl;

    localparam int unsigned MC = 32;
    localparam int unsigned DC = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] divisor = '0;
    logic        init_mult, init_div, op_hi, op_lo, hi_write, lo_write, busy, done, div_zero;

    int checks = 0;
    int failures = 0;

    muldiv_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_mult_i (start_mult),
        .start_div_i  (start_div),
        .flush_i      (flush),
        .divisor_i    (divisor),
        .init_mult_o  (init_mult),
        .init_div_o   (init_div),
        .op_hi_o      (op_hi),
        .op_lo_o      (op_lo),
        .hi_write_o   (hi_write),
        .lo_write_o   (lo_write),
        .busy_o       (busy),
        .done_o       (done),
        .div_zero_o   (div_zero)
    );

    always #5 clk = ~clk;

    // {init_mult, init_div, op_hi, op_lo, hi_write, lo_write, busy, done, div_zero}
    logic [8:0] obs;
    assign obs = {init_mult, init_div, op_hi, op_lo, hi_write, lo_write, busy, done, div_zero};

    function automatic logic [8:0] ev(input bit im, input bit id, input bit [1:0] op,
                                      input bit wr, input bit bz, input bit dn, input bit dz);
        return {im, id, op, wr, wr, bz, dn, dz};
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at cycle 0, check cycles 1..n+1 and the idle cycle n+2.
    task automatic run_op(input string name, input bit sm, input bit sd, input int n,
                          input bit [1:0] op);
        start_mult = sm;
        start_div  = sd;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        for (int c = 1; c <= n + 1; c++) begin
            chk($sformatf("%s_c%0d", name, c),
                ev(sm && c == 1, !sm && c == 1, op, c == n + 1, 1'b1, c == n + 1, 1'b0));
            if (c < n + 1) tick();
        end
        tick();
        chk({name, "_idle"}, ev(0, 0, op, 0, 0, 0, 0));
    endtask

    initial begin
        #12;
        chk("reset_hold", ev(0, 0, 2'b00, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_released", ev(0, 0, 2'b00, 0, 0, 0, 0));

        run_op("mult", 1'b1, 1'b0, MC, 2'b11);

        // Starts on the cycle right after WRITE.
        divisor = 32'd7;
        run_op("div7_b2b", 1'b0, 1'b1, DC, 2'b00);

        divisor = '0;
        start_div = 1'b1;
        tick();
        start_div = 1'b0;
        chk("divz_c1", ev(0, 0, 2'b00, 0, 1, 1, 1));
        tick();
        chk("divz_idle", ev(0, 0, 2'b00, 0, 0, 0, 0));

        run_op("both_div0", 1'b1, 1'b1, MC, 2'b11);

        start_div = 1'b1;
        tick();
        start_div = 1'b0;
        chk("divz_keep_op", ev(0, 0, 2'b11, 0, 1, 1, 1));
        tick();

        // Flush at cycle 20 of a divide, with ignored restarts along the way.
        divisor = 32'd7;
        start_div = 1'b1;
        tick();
        start_div = 1'b0;
        chk("fl_c1", ev(0, 1, 2'b00, 0, 1, 0, 0));
        tick();
        for (int c = 2; c <= 20; c++) begin
            chk($sformatf("fl_c%0d", c), ev(0, 0, 2'b00, 0, 1, 0, 0));
            start_div  = (c == 5);
            start_mult = (c == 7);
            flush      = (c == 20);
            tick();
        end
        start_div  = 1'b0;
        start_mult = 1'b0;
        flush      = 1'b0;
        for (int c = 21; c <= 33; c++) begin
            chk($sformatf("fl_idle_c%0d", c), ev(0, 0, 2'b00, 0, 0, 0, 0));
            tick();
        end
        run_op("after_flush", 1'b1, 1'b0, MC, 2'b11);

        // Flush on the count-zero cycle must suppress WRITE.
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        for (int c = 1; c < 32; c++) tick();
        chk("flz_c32", ev(0, 0, 2'b11, 0, 1, 0, 0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flz_c33", ev(0, 0, 2'b11, 0, 0, 0, 0));
        tick();
        chk("flz_c34", ev(0, 0, 2'b11, 0, 0, 0, 0));

        // Flush beats a start in IDLE.
        flush = 1'b1;
        start_div = 1'b1;
        tick();
        flush = 1'b0;
        start_div = 1'b0;
        chk("flush_vs_start", ev(0, 0, 2'b11, 0, 0, 0, 0));

        // Asynchronous reset mid-multiply at cycle 10.
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("rst_pre_c10", ev(0, 0, 2'b11, 0, 1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_run", ev(0, 0, 2'b00, 0, 0, 0, 0));
        tick();
        chk("rst_held", ev(0, 0, 2'b00, 0, 0, 0, 0));
        rst_n = 1'b1;
        run_op("post_rst", 1'b1, 1'b0, MC, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 32, cycles the multiplier needs from init_mult to a valid result; legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 32, cycles the divider needs from init_div to a valid result; legal range 1..63.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start_mult  in  1  one-cycle request from control unit (MULT/MULTU).
REQ-006 start_div  in  1  one-cycle request from control unit (DIV/DIVU).
REQ-007 flush  in  1  synchronous abort; returns to IDLE without HI/LO write.
REQ-008 divisor  in  32  B register value, sampled with start_div.
REQ-009 init_mult  out  1  one-cycle start pulse to mult unit.
REQ-010 init_div  out  1  one-cycle start pulse to div unit.
REQ-011 op_hi  out  1  HI mux select; 0 = div result, 1 = mult result.
REQ-012 op_lo  out  1  LO mux select; same encoding as op_hi.
REQ-013 hi_write  out  1  HI register load enable.
REQ-014 lo_write  out  1  LO register load enable.
REQ-015 busy  out  1  operation in progress; control unit stalls while high.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 div_zero  out  1  one-cycle divide-by-zero exception request (drives cause logic).

Function
REQ-018 All outputs SHALL be registered (Moore); states IDLE, MULT_RUN, DIV_RUN, WRITE, DIVZ.
REQ-019 IDLE: start_mult=1 -> MULT_RUN, counter loaded MULT_CYCLES-1, init_mult=1 for the first MULT_RUN cycle only, op_hi=op_lo=1.
REQ-020 IDLE: start_div=1, start_mult=0, divisor!=0 -> DIV_RUN, counter loaded DIV_CYCLES-1, init_div=1 for the first DIV_RUN cycle only, op_hi=op_lo=0.
REQ-021 IDLE: start_div=1, start_mult=0, divisor==0 -> DIVZ; init_div never asserted.
REQ-022 start_mult and start_div both high in IDLE: multiply wins, divide request dropped.
REQ-023 MULT_RUN/DIV_RUN: counter decrements once per cycle; at count 0 the next state is WRITE.
REQ-024 WRITE: exactly one cycle; hi_write=lo_write=1, done=1, busy=1; op_hi/op_lo held from start; next state IDLE.
REQ-025 DIVZ: exactly one cycle; div_zero=1, done=1, busy=1, hi_write=lo_write=0; next state IDLE.
REQ-026 busy=1 in every non-IDLE state; busy=0 in IDLE.
REQ-027 Latency: start sampled at edge k -> busy high cycles k+1..k+N+1, WRITE at cycle k+N+1 (N = MULT_CYCLES or DIV_CYCLES); back-to-back start accepted on the cycle after WRITE.
REQ-028 start_mult/start_div while busy=1 SHALL be ignored (no queuing).
REQ-029 flush=1 in any state -> IDLE next edge; no hi_write, lo_write, done or div_zero that cycle; flush has priority over start and over counter expiry.
REQ-030 op_hi/op_lo SHALL retain their last value in IDLE.

Reset
REQ-031 reset low SHALL force IDLE immediately, independent of clk.
REQ-032 Reset values: counter=0, op_hi=op_lo=0, init_mult=init_div=hi_write=lo_write=busy=done=div_zero=0.
REQ-033 Reset asserted mid-operation SHALL abort it with no HI/LO write; first start accepted on the first edge after reset release.

Structure
REQ-034 Shared package muldiv_pkg holds the state enumeration, OP_DIV=0 / OP_MULT=1 select constants and the 6-bit counter width.
REQ-035 One sub-module, muldiv_cnt: loadable 6-bit down-counter with load, dec, zero flag, same clk/reset.
REQ-036 Block SHALL contain no arithmetic on data operands; the only data-path input is the divisor zero-compare.

Verification
REQ-037 Reset low mid-MULT_RUN (cycle 10): all outputs 0 same cycle; after release, start_mult -> normal run, no stray hi_write.
REQ-038 start_mult at cycle 0 (MULT_CYCLES=32): init_mult at cycle 1, busy cycles 1..33, hi_write=lo_write=done=1 at cycle 33 only, op_hi=op_lo=1.
REQ-039 start_div, divisor=7: init_div at cycle 1, WRITE at cycle 33, op_hi=op_lo=0; divisor=0 -> div_zero=done=1 at cycle 1, no init_div, no write.
REQ-040 start_mult and start_div together, divisor=0: multiply runs, div_zero never asserted.
REQ-041 flush at cycle 20 of DIV_RUN: IDLE at cycle 21, no write/done; start_div repeated while busy ignored; back-to-back start at cycle 34 accepted.
